systolic_array_nxn: RTL and testbench
=====================================

SYSTOLIC_ARRAY_NXN -- requirements
Module: systolic_array_nxn

Interface
REQ-001 Parameter N, default 4, array dimension (N x N PEs, N >= 2).
REQ-002 Parameter IN_W, default 8, signed operand width.
REQ-003 Parameter ACC_W, default 32, signed accumulator width (ACC_W >= 2*IN_W).
REQ-004 Parameter K_W, default 16, width of the reduction-length port.
REQ-005 clk  in  1  single clock; all state on rising edge.
REQ-006 reset  in  1  asynchronous, active-high; clears all state.
REQ-007 start  in  1  one-cycle request to begin a matrix product.
REQ-008 k_len  in  K_W  reduction length K, sampled when start is accepted.
REQ-009 in_valid  in  1  a_col/b_row beat is valid.
REQ-010 in_ready  out  1  array accepts a beat this cycle.
REQ-011 a_col  in  N*IN_W  column k of A; lane i = A[i][k], lane 0 in LSBs.
REQ-012 b_row  in  N*IN_W  row k of B; lane j = B[k][j], lane 0 in LSBs.
REQ-013 c_valid  out  1  c_row holds a result row.
REQ-014 c_ready  in  1  consumer accepts c_row.
REQ-015 c_row  out  N*ACC_W  row r of C; lane j = C[r][j], lane 0 in LSBs.
REQ-016 c_row_idx  out  clog2(N)  row index r of c_row.
REQ-017 busy  out  1  high in any state other than IDLE.
REQ-018 done  out  1  one-cycle pulse when the product is fully drained.

Function
REQ-019 FSM states SHALL be IDLE, FEED, FLUSH, DRAIN.
- IDLE: start=1 -> clear all accumulators and skew registers, latch k_len; go to FEED if k_len>0, else DRAIN.
- FEED: in_ready=1; beat accepted when in_valid & in_ready; after the K-th accepted beat -> FLUSH.
- FLUSH: counter runs 2N-1 cycles, then -> DRAIN.
- DRAIN: rows r=0..N-1 presented in order; advance on c_valid & c_ready; after row N-1 accepted -> IDLE with done=1 that cycle.
REQ-020 start SHALL be ignored while busy=1.
REQ-021 Input skew: lane i of a_col SHALL be delayed i cycles before entering row i; lane j of b_row delayed j cycles before entering column j.
REQ-022 Each PE(i,j) SHALL register its a operand rightward and its b operand downward, one cycle per hop.
REQ-023 The array SHALL advance every cycle in FEED and FLUSH; a cycle without an accepted beat (FEED with in_valid=0, and all FLUSH cycles) SHALL inject zero on all lanes.
REQ-024 Each PE SHALL compute acc <= acc + sext(a*b), product 2*IN_W signed, sign-extended to ACC_W, wrapping modulo 2^ACC_W with no saturation.
REQ-025 The array SHALL hold (no shift, no accumulate) in IDLE and DRAIN.
REQ-026 In DRAIN, c_valid=1, c_row = accumulators of row c_row_idx; c_row and c_row_idx SHALL be stable while c_valid & !c_ready.
REQ-027 Outside DRAIN, c_valid=0, c_row=0, c_row_idx=0; in_ready=0 outside FEED.
REQ-028 k_len=0 SHALL yield N rows of zeros.
REQ-029 Latency: the first c_valid SHALL assert exactly 2N-1 cycles after the cycle the K-th beat is accepted, plus one cycle for the FLUSH->DRAIN transition.

Reset
REQ-030 On reset assertion, regardless of state, the FSM SHALL enter IDLE and all accumulators, skew and PE registers, and counters SHALL clear asynchronously.
REQ-031 Reset values: in_ready=0, c_valid=0, c_row=0, c_row_idx=0, busy=0, done=0.
REQ-032 A product interrupted by reset SHALL be discarded; no done pulse.

Verification
REQ-033 N=2, K=2, A=[1 2;3 4], B=[5 6;7 8], c_ready=1, in_valid=1 -> rows {19,22},{43,50}, idx 0,1, done one cycle after row 1.
REQ-034 N=4, K=4, A=I, B random signed -> C=B; repeat with in_valid bubbles every other cycle -> identical C.
REQ-035 N=2, K=3, all operands -128 -> every C entry 49152; K=65535 with all 127 -> each C entry = 65535*16129 mod 2^32, interpreted signed.
REQ-036 k_len=0 -> FEED skipped, N rows of zeros, done pulse; start during busy -> ignored, result unchanged.
REQ-037 c_ready low 3 cycles on row 1 -> c_row/c_row_idx held constant, no row skipped or duplicated.
REQ-038 reset pulsed mid-FEED and mid-DRAIN -> all outputs zero next edge, busy=0, next product correct with no residue.

Source files
------------

// File: rtl/systolic_array_nxn.sv
// systolic_array_nxn: output-stationary N x N signed MAC array.
// A columns enter from the west, B rows from the north, each lane skewed so
// that A[i][k] and B[k][j] meet in PE(i,j). Results drain one row per handshake.

// One processing element: multiply-accumulate into a wrapping accumulator.
module systolic_pe #(
  parameter int IN_W  = 8,
  parameter int ACC_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             adv,
  input  logic [IN_W-1:0]  a,
  input  logic [IN_W-1:0]  b,
  output logic [ACC_W-1:0] acc
);
  logic signed [2*IN_W-1:0] prod;
  logic signed [ACC_W-1:0]  prod_x;

  assign prod   = (2*IN_W)'($signed(a)) * (2*IN_W)'($signed(b));
  assign prod_x = ACC_W'(prod);

  // accumulate only while the array advances; modulo 2^ACC_W, no saturation
  always_ff @(posedge clk or posedge reset) begin
    if (reset)    acc <= '0;
    else if (clr) acc <= '0;
    else if (adv) acc <= acc + prod_x;
  end
endmodule

module systolic_array_nxn #(
  parameter int N     = 4,
  parameter int IN_W  = 8,
  parameter int ACC_W = 32,
  parameter int K_W   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [K_W-1:0]       k_len,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N*IN_W-1:0]    a_col,
  input  logic [N*IN_W-1:0]    b_row,
  output logic                 c_valid,
  input  logic                 c_ready,
  output logic [N*ACC_W-1:0]   c_row,
  output logic [$clog2(N)-1:0] c_row_idx,
  output logic                 busy,
  output logic                 done
);
  localparam int RW = $clog2(N);
  localparam int FW = $clog2(2*N);

  typedef enum logic [1:0] {IDLE, FEED, FLUSH, DRAIN} state_t;

  state_t                           state;
  logic [K_W-1:0]                   k_q, k_cnt;
  logic [FW-1:0]                    fl_cnt;
  logic [RW-1:0]                    row;
  logic                             done_q;
  logic                             beat, clr, adv;
  logic [N-1:0][IN_W-1:0]           a_inj, b_inj, a_sk, b_sk;
  logic [N-1:0][N-1:0][ACC_W-1:0]   acc_m;
  logic [IN_W-1:0]                  a_hop [N][N-1];
  logic [IN_W-1:0]                  b_hop [N-1][N];

  assign beat  = in_valid && (state == FEED);
  assign clr   = start && (state == IDLE);
  assign adv   = (state == FEED) || (state == FLUSH);
  // idle array cycles push zeros so stale operands never accumulate
  assign a_inj = beat ? a_col : '0;
  assign b_inj = beat ? b_row : '0;

  assign in_ready  = (state == FEED);
  assign busy      = (state != IDLE);
  assign c_valid   = (state == DRAIN);
  assign c_row     = c_valid ? acc_m[row] : '0;
  assign c_row_idx = row;
  assign done      = done_q;

  // control: feed K beats, flush 2N-1 cycles, hand out N rows
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      k_q    <= '0;
      k_cnt  <= '0;
      fl_cnt <= '0;
      row    <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: if (start) begin
          k_q    <= k_len;
          k_cnt  <= '0;
          fl_cnt <= '0;
          row    <= '0;
          state  <= (k_len == '0) ? DRAIN : FEED;
        end
        FEED: if (beat) begin
          if (k_cnt == k_q - K_W'(1)) state <= FLUSH;
          else                        k_cnt <= k_cnt + 1'b1;
        end
        FLUSH: begin
          if (fl_cnt == FW'(2*N-2)) state  <= DRAIN;
          else                      fl_cnt <= fl_cnt + 1'b1;
        end
        DRAIN: if (c_ready) begin
          if (row == RW'(N-1)) begin
            state  <= IDLE;
            row    <= '0;
            done_q <= 1'b1;
          end else begin
            row <= row + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // lane 0 enters the array with no skew
  assign a_sk[0] = a_inj[0];
  assign b_sk[0] = b_inj[0];

  for (genvar i = 1; i < N; i++) begin : g_skew
    logic [IN_W-1:0] a_d [i];
    logic [IN_W-1:0] b_d [i];
    // lane i delayed i advancing cycles before entering row/column i
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        for (int k = 0; k < i; k++) begin a_d[k] <= '0; b_d[k] <= '0; end
      end else if (clr) begin
        for (int k = 0; k < i; k++) begin a_d[k] <= '0; b_d[k] <= '0; end
      end else if (adv) begin
        a_d[0] <= a_inj[i];
        b_d[0] <= b_inj[i];
        for (int k = 1; k < i; k++) begin a_d[k] <= a_d[k-1]; b_d[k] <= b_d[k-1]; end
      end
    end
    assign a_sk[i] = a_d[i-1];
    assign b_sk[i] = b_d[i-1];
  end

  // operand hops: a moves one PE east, b one PE south, per advancing cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N; i++) for (int j = 0; j < N-1; j++) a_hop[i][j] <= '0;
      for (int i = 0; i < N-1; i++) for (int j = 0; j < N; j++) b_hop[i][j] <= '0;
    end else if (clr) begin
      for (int i = 0; i < N; i++) for (int j = 0; j < N-1; j++) a_hop[i][j] <= '0;
      for (int i = 0; i < N-1; i++) for (int j = 0; j < N; j++) b_hop[i][j] <= '0;
    end else if (adv) begin
      for (int i = 0; i < N; i++) begin
        a_hop[i][0] <= a_sk[i];
        for (int j = 1; j < N-1; j++) a_hop[i][j] <= a_hop[i][j-1];
      end
      for (int j = 0; j < N; j++) begin
        b_hop[0][j] <= b_sk[j];
        for (int i = 1; i < N-1; i++) b_hop[i][j] <= b_hop[i-1][j];
      end
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      logic [IN_W-1:0] a_pe, b_pe;
      if (j == 0) begin : g_aw
        assign a_pe = a_sk[i];
      end else begin : g_ah
        assign a_pe = a_hop[i][j-1];
      end
      if (i == 0) begin : g_bn
        assign b_pe = b_sk[j];
      end else begin : g_bh
        assign b_pe = b_hop[i-1][j];
      end
      systolic_pe #(.IN_W(IN_W), .ACC_W(ACC_W)) u_pe (
        .clk(clk), .reset(reset), .clr(clr), .adv(adv),
        .a(a_pe), .b(b_pe), .acc(acc_m[i][j])
      );
    end
  end
endmodule

// File: tb/tb_systolic_array_nxn.sv
// Directed bench for systolic_array_nxn: a 2x2 and a 4x4 instance share clock/reset.
module tb_systolic_array_nxn;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // 2x2 instance
  logic        s2_start, s2_iv, s2_ir, s2_cv, s2_cr, s2_busy, s2_done;
  logic [15:0] s2_k, s2_a, s2_b;
  logic [63:0] s2_c;
  logic [0:0]  s2_idx;
  // 4x4 instance
  logic         s4_start, s4_iv, s4_ir, s4_cv, s4_cr, s4_busy, s4_done;
  logic [15:0]  s4_k;
  logic [31:0]  s4_a, s4_b;
  logic [127:0] s4_c;
  logic [1:0]   s4_idx;

  systolic_array_nxn #(.N(2)) dut2 (
    .clk(clk), .reset(rst), .start(s2_start), .k_len(s2_k), .in_valid(s2_iv),
    .in_ready(s2_ir), .a_col(s2_a), .b_row(s2_b), .c_valid(s2_cv), .c_ready(s2_cr),
    .c_row(s2_c), .c_row_idx(s2_idx), .busy(s2_busy), .done(s2_done));

  systolic_array_nxn #(.N(4)) dut4 (
    .clk(clk), .reset(rst), .start(s4_start), .k_len(s4_k), .in_valid(s4_iv),
    .in_ready(s4_ir), .a_col(s4_a), .b_row(s4_b), .c_valid(s4_cv), .c_ready(s4_cr),
    .c_row(s4_c), .c_row_idx(s4_idx), .busy(s4_busy), .done(s4_done));

  // beat tables for the 2x2: A=[1 2;3 4], B=[5 6;7 8]
  logic [15:0] t2_a [8];
  logic [15:0] t2_b [8];
  localparam logic [63:0] E2_R0 = {32'd22, 32'd19};
  localparam logic [63:0] E2_R1 = {32'd50, 32'd43};

  // B for the identity product
  int bm [4][4] = '{'{-7, 12, 127, -128}, '{33, -1, 0, 5},
                    '{-64, 99, -100, 2}, '{1, -2, 88, -55}};

  logic [63:0]  r2_row [2];
  logic [0:0]   r2_idx [2];
  int           r2_lat;
  bit           r2_to, r2_done, r2_busy;
  logic [127:0] r4_row [4];
  logic [1:0]   r4_idx [4];
  int           r4_lat;
  bit           r4_to, r4_done;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // drive one 2x2 product; optionally bubble input, hold start high while busy, drain
  task automatic run2(input int k, input bit fill, input logic [7:0] fv,
                      input bit bub, input bit spam, input bit drain);
    int beat = 0;
    int cyc = 0;
    bit acc;
    r2_to = 0; r2_done = 0; r2_busy = 1;
    s2_start = 1; s2_k = k[15:0]; tick();
    s2_start = spam; s2_k = 16'd7;
    while (beat < k && !r2_to) begin
      s2_iv = !(bub && cyc[0]);
      s2_a  = fill ? {fv, fv} : t2_a[beat[2:0]];
      s2_b  = fill ? {fv, fv} : t2_b[beat[2:0]];
      acc   = s2_iv && s2_ir;
      tick(); cyc++;
      if (acc) beat++;
      if (cyc > 2*k + 16) r2_to = 1;
    end
    s2_iv = 0; s2_a = '0; s2_b = '0;
    r2_lat = (k == 0) ? 0 : 1;
    while (!s2_cv && r2_lat < 64) begin tick(); r2_lat++; end
    if (!s2_cv) r2_to = 1;
    s2_start = 0;
    if (drain) begin
      s2_cr = 1;
      for (int r = 0; r < 2; r++) begin
        r2_row[r] = s2_c; r2_idx[r] = s2_idx;
        if (!s2_cv) r2_to = 1;
        tick();
      end
      r2_done = s2_done; r2_busy = s2_busy;
    end
  endtask

  // 4x4 product A=I times bm, optional input bubbles every other cycle
  task automatic run4(input bit bub);
    int beat = 0;
    int cyc = 0;
    bit acc;
    r4_to = 0; r4_done = 0;
    s4_start = 1; s4_k = 16'd4; tick();
    s4_start = 0;
    while (beat < 4 && !r4_to) begin
      s4_iv = !(bub && cyc[0]);
      s4_a = '0;
      s4_a[beat*8 +: 8] = 8'd1;
      for (int j = 0; j < 4; j++) s4_b[j*8 +: 8] = 8'(bm[beat][j]);
      acc = s4_iv && s4_ir;
      tick(); cyc++;
      if (acc) beat++;
      if (cyc > 40) r4_to = 1;
    end
    s4_iv = 0; s4_a = '0; s4_b = '0;
    r4_lat = 1;
    while (!s4_cv && r4_lat < 64) begin tick(); r4_lat++; end
    if (!s4_cv) r4_to = 1;
    s4_cr = 1;
    for (int r = 0; r < 4; r++) begin
      r4_row[r] = s4_c; r4_idx[r] = s4_idx;
      if (!s4_cv) r4_to = 1;
      tick();
    end
    r4_done = s4_done;
  endtask

  task automatic test_reset();
    rst = 1; tick();
    checks++;
    if ({s2_ir, s2_cv, s2_c, s2_idx, s2_busy, s2_done} !== '0) begin
      failures++;
      $display("FAIL reset_dut2 got=%h exp=0", {s2_ir, s2_cv, s2_c, s2_idx, s2_busy, s2_done});
    end
    checks++;
    if ({s4_ir, s4_cv, s4_c, s4_idx, s4_busy, s4_done} !== '0) begin
      failures++;
      $display("FAIL reset_dut4 got=%h exp=0", {s4_ir, s4_cv, s4_c, s4_idx, s4_busy, s4_done});
    end
    rst = 0; tick();
  endtask

  task automatic test_basic();
    run2(2, 0, 8'd0, 0, 0, 1);
    checks++; if (r2_to) begin failures++; $display("FAIL basic_timeout got=1 exp=0"); end
    checks++; if (r2_row[0] !== E2_R0) begin failures++; $display("FAIL basic_row0 got=%h exp=%h", r2_row[0], E2_R0); end
    checks++; if (r2_row[1] !== E2_R1) begin failures++; $display("FAIL basic_row1 got=%h exp=%h", r2_row[1], E2_R1); end
    checks++; if (r2_idx[0] !== 1'b0 || r2_idx[1] !== 1'b1) begin failures++; $display("FAIL basic_idx got=%b%b exp=01", r2_idx[0], r2_idx[1]); end
    checks++; if (r2_lat !== 4) begin failures++; $display("FAIL basic_latency got=%0d exp=4", r2_lat); end
    checks++; if (r2_done !== 1'b1 || r2_busy !== 1'b0) begin failures++; $display("FAIL basic_done got=%b busy=%b exp=1 busy=0", r2_done, r2_busy); end
    tick();
    checks++; if (s2_done !== 1'b0) begin failures++; $display("FAIL basic_done_pulse got=%b exp=0", s2_done); end
  endtask

  task automatic test_identity();
    logic [127:0] exp;
    for (int pass = 0; pass < 2; pass++) begin
      run4(pass[0]);
      checks++; if (r4_to) begin failures++; $display("FAIL ident_timeout pass=%0d", pass); end
      if (pass == 0) begin
        checks++; if (r4_lat !== 8) begin failures++; $display("FAIL ident_latency got=%0d exp=8", r4_lat); end
      end
      for (int r = 0; r < 4; r++) begin
        for (int j = 0; j < 4; j++) exp[j*32 +: 32] = 32'(bm[r][j]);
        checks++;
        if (r4_row[r] !== exp || r4_idx[r] !== 2'(r)) begin
          failures++;
          $display("FAIL ident_row%0d pass=%0d got=%h idx=%0d exp=%h", r, pass, r4_row[r], r4_idx[r], exp);
        end
      end
      checks++; if (r4_done !== 1'b1) begin failures++; $display("FAIL ident_done got=%b exp=1", r4_done); end
    end
  endtask

  task automatic test_extremes();
    logic [63:0] e;
    run2(3, 1, 8'h80, 0, 0, 1);
    e = {2{32'd49152}};
    checks++; if (r2_row[0] !== e || r2_row[1] !== e) begin failures++; $display("FAIL neg128 got=%h %h exp=%h", r2_row[0], r2_row[1], e); end
    run2(65535, 1, 8'h7f, 0, 0, 1);
    e = {2{32'd1057014015}};
    checks++; if (r2_to) begin failures++; $display("FAIL long_timeout got=1 exp=0"); end
    checks++; if (r2_row[0] !== e || r2_row[1] !== e) begin failures++; $display("FAIL long_k got=%h %h exp=%h", r2_row[0], r2_row[1], e); end
  endtask

  task automatic test_zero_k_and_busy_start();
    run2(0, 0, 8'd0, 0, 0, 1);
    checks++; if (r2_row[0] !== 64'd0 || r2_row[1] !== 64'd0) begin failures++; $display("FAIL zero_k_rows got=%h %h exp=0", r2_row[0], r2_row[1]); end
    checks++; if (r2_idx[1] !== 1'b1 || r2_done !== 1'b1) begin failures++; $display("FAIL zero_k_done got idx=%b done=%b exp idx=1 done=1", r2_idx[1], r2_done); end
    run2(2, 0, 8'd0, 1, 1, 1);
    checks++; if (r2_row[0] !== E2_R0 || r2_row[1] !== E2_R1) begin failures++; $display("FAIL busy_start got=%h %h exp=%h %h", r2_row[0], r2_row[1], E2_R0, E2_R1); end
  endtask

  task automatic test_backpressure();
    run2(2, 0, 8'd0, 0, 0, 0);
    s2_cr = 1;
    checks++; if (s2_idx !== 1'b0 || s2_c !== E2_R0) begin failures++; $display("FAIL bp_row0 got=%h idx=%b exp=%h", s2_c, s2_idx, E2_R0); end
    tick();
    s2_cr = 0;
    for (int s = 0; s < 3; s++) begin
      checks++;
      if (s2_cv !== 1'b1 || s2_idx !== 1'b1 || s2_c !== E2_R1) begin
        failures++; $display("FAIL bp_hold%0d got=%h idx=%b v=%b exp=%h", s, s2_c, s2_idx, s2_cv, E2_R1);
      end
      tick();
    end
    checks++; if (s2_idx !== 1'b1 || s2_c !== E2_R1) begin failures++; $display("FAIL bp_release got=%h idx=%b exp=%h", s2_c, s2_idx, E2_R1); end
    s2_cr = 1; tick();
    checks++; if (s2_done !== 1'b1 || s2_cv !== 1'b0) begin failures++; $display("FAIL bp_done got done=%b v=%b exp done=1 v=0", s2_done, s2_cv); end
  endtask

  task automatic test_reset_mid();
    // mid-FEED
    s2_start = 1; s2_k = 16'd2; tick(); s2_start = 0;
    s2_iv = 1; s2_a = t2_a[0]; s2_b = t2_b[0]; tick();
    s2_iv = 0; rst = 1; #1;
    checks++;
    if ({s2_ir, s2_cv, s2_c, s2_idx, s2_busy, s2_done} !== '0) begin
      failures++; $display("FAIL rst_feed got=%h exp=0", {s2_ir, s2_cv, s2_c, s2_idx, s2_busy, s2_done});
    end
    tick(); rst = 0;
    checks++; if (s2_done !== 1'b0 || s2_busy !== 1'b0) begin failures++; $display("FAIL rst_feed_nodone got done=%b busy=%b exp 0 0", s2_done, s2_busy); end
    run2(2, 0, 8'd0, 0, 0, 1);
    checks++; if (r2_row[0] !== E2_R0 || r2_row[1] !== E2_R1) begin failures++; $display("FAIL rst_feed_next got=%h %h exp=%h %h", r2_row[0], r2_row[1], E2_R0, E2_R1); end
    // mid-DRAIN
    run2(2, 0, 8'd0, 0, 0, 0);
    s2_cr = 0; tick();
    rst = 1; #1;
    checks++;
    if ({s2_ir, s2_cv, s2_c, s2_idx, s2_busy, s2_done} !== '0) begin
      failures++; $display("FAIL rst_drain got=%h exp=0", {s2_ir, s2_cv, s2_c, s2_idx, s2_busy, s2_done});
    end
    tick(); rst = 0; s2_cr = 1;
    run2(2, 0, 8'd0, 0, 0, 1);
    checks++; if (r2_row[0] !== E2_R0 || r2_row[1] !== E2_R1) begin failures++; $display("FAIL rst_drain_next got=%h %h exp=%h %h", r2_row[0], r2_row[1], E2_R0, E2_R1); end
  endtask

  initial begin
    rst = 1;
    s2_start = 0; s2_k = '0; s2_iv = 0; s2_a = '0; s2_b = '0; s2_cr = 1;
    s4_start = 0; s4_k = '0; s4_iv = 0; s4_a = '0; s4_b = '0; s4_cr = 1;
    t2_a = '{default: '0};
    t2_b = '{default: '0};
    t2_a[0] = {8'd3, 8'd1}; t2_a[1] = {8'd4, 8'd2};
    t2_b[0] = {8'd6, 8'd5}; t2_b[1] = {8'd8, 8'd7};
    test_reset();
    test_basic();
    test_identity();
    test_extremes();
    test_zero_k_and_busy_start();
    test_backpressure();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end
endmodule
